lane_packer: RTL and testbench
==============================

Name: lane_packer

Overview:
- Stage directly downstream of the lane shifter. Consumes left-justified beats: lanes 0..in_count-1 are valid and upper lanes are zero.
- Concatenates consecutive beats into dense, full LANES-wide output words, so a stream of partial beats becomes full-width traffic.
- On an end-of-packet marker, flushes the remainder as a zero-padded partial word tagged with out_last.
- Valid/ready handshake on both sides; output driven from registers.

Parameters:
LANES, 16, lanes per input/output word
LANE_W, 16, bits per lane
CNT_W, $clog2(LANES)+1, width of lane-count fields (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  packer accepts beat this cycle
in_data  input  LANES x LANE_W  left-justified lanes from the lane shifter
in_count  input  CNT_W  valid lanes in beat, 0..LANES
in_last  input  1  beat ends packet, triggers flush
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts word
out_data  output  LANES x LANE_W  packed word, lane 0 oldest
out_count  output  CNT_W  valid lanes in out_data (LANES except on flush remainder)
out_last  output  1  final word of packet

Behaviour:
- Storage: buf of 2*LANES lanes plus fill (0..2*LANES-1). Lanes at or above fill are always zero.
- Reset (async, rst_n=0): buf=0, fill=0, state=ACCUM. Outputs: out_valid=0, out_last=0, out_count=0, out_data=0, in_ready=0 while rst_n low.
- States:
  - ACCUM: normal packing.
  - FLUSH: draining after in_last; in_ready=0.
- pop = out_valid && out_ready.
- push = in_valid && in_ready.
- in_ready = (state==ACCUM) && (fill<LANES || pop). The out_ready->in_ready combinational path is intentional. in_ready never depends on in_valid/in_data/in_count.
- in_count > LANES is clamped to LANES. Lanes of in_data at or above in_count are ignored and written as zero.
- out_valid:
  - In ACCUM: out_valid = (fill>=LANES).
  - In FLUSH: out_valid = (fill>0).
- out_data = buf[0..LANES-1].
- out_count = min(fill, LANES) when out_valid, else 0.
- out_last = (state==FLUSH) && (fill<=LANES).
- Update per cycle:
  - base = pop ? fill-LANES : fill (saturates at 0 in FLUSH with fill<LANES).
  - On pop: buf shifts down LANES lanes; the upper lanes are zero-filled.
  - On push: beat lanes are written at buf[base .. base+cnt-1]; fill_next = base+cnt.
- Latency: a beat accepted at edge N makes out_valid visible after edge N (first cycle N+1) if fill reaches LANES. No bubble when full beats stream and out_ready=1 (one word per cycle).
- push with in_last goes to FLUSH. The flush beat's own lanes are included.
- FLUSH exits to ACCUM on the pop where out_last=1; fill becomes 0.
- in_last with in_count=0 and fill==0: no word is emitted; FLUSH exits to ACCUM next cycle.
- Backpressure: out_valid/out_data/out_count/out_last stay stable while out_valid && !out_ready.
- Max fill: 15+16=31, so no overflow is possible under the in_ready rule.
- rst_n low mid-packet discards buffered lanes and all state immediately, regardless of clk.

Decomposition:
- Shared package lane_pkg holds:
  - LANES and LANE_W localparams.
  - lane_t (logic [LANE_W-1:0]).
  - word_t (lane_t [LANES-1:0]).
  - cnt_t.
  - state_e {ACCUM, FLUSH}.
- The lane shifter and this block both import lane_pkg.
- One sub-module, lane_place_at: a combinational barrel placer. It writes a clamped beat into the 2*LANES vector at lane offset base and zero-masks lanes at or above the count. It keeps the sequential top to state, fill and handshake logic.

Test Plan:
- Four beats with in_count=4, lane values 1..16 in order, out_ready=1 -> one word, out_data lanes 0..15 = 1..16, out_count=16, out_last=0, out_valid one cycle after the 4th accept.
- Beats with counts 10 then 10 (in_last on the 2nd) -> word 1 with count 16, out_last=0; word 2 with count 4, lanes 4..15 zero, out_last=1; state returns to ACCUM, fill=0.
- Continuous full beats (count=16) with out_ready=1 for 8 cycles -> in_ready stays 1 and 8 words out, back-to-back.
- Hold out_ready=0 with fill=20 -> in_ready=0, out_data stable. Raise out_ready -> pop, and a beat accepted the same cycle lands at lane 4.
- in_count=20 clamps to 16, and garbage in lanes at or above in_count is written as zero. in_last with count=0 and fill=0 -> no output, next beat accepted after 1 cycle.
- Assert rst_n=0 asynchronously mid-FLUSH with fill=12 -> out_valid drops immediately, no out_last emitted; after release, in_ready=1 and fill=0.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared lane-stream definitions used by the lane shifter and the lane packer.
package lane_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned CNT_W  = $clog2(LANES) + 1;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/lane_place_at.sv
// Combinational barrel placer: drops the first `count` lanes of a beat into a
// double-width lane vector starting at lane `base`; every other lane is zero.
module lane_place_at #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned CNT_W  = $clog2(LANES) + 1,
    parameter int unsigned BASE_W = $clog2(2 * LANES)
) (
    input  logic [LANES-1:0][LANE_W-1:0]   beat,
    input  logic [CNT_W-1:0]               count,
    input  logic [BASE_W-1:0]              base,
    output logic [2*LANES-1:0][LANE_W-1:0] placed
);

    logic [2*LANES-1:0][LANE_W-1:0] wide;

    always_comb begin
        wide = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (CNT_W'(i) < count) begin
                wide[i] = beat[i];
            end
        end
        placed = wide << (base * LANE_W);
    end

endmodule

// File: rtl/lane_packer.sv
// Packs left-justified partial beats into dense full-width words; in_last
// flushes the remainder as a zero-padded word tagged with out_last.
module lane_packer #(
    parameter int unsigned  LANES  = lane_pkg::LANES,
    parameter int unsigned  LANE_W = lane_pkg::LANE_W,
    localparam int unsigned CNT_W  = $clog2(LANES) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0][LANE_W-1:0]  in_data,
    input  logic [CNT_W-1:0]              in_count,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0][LANE_W-1:0]  out_data,
    output logic [CNT_W-1:0]              out_count,
    output logic                          out_last
);

    import lane_pkg::*;

    localparam int unsigned      FILL_W    = $clog2(2 * LANES);
    localparam int unsigned      WORD_BITS = LANES * LANE_W;
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(LANES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(LANES);

    state_e                          state, state_next;
    logic [2*LANES-1:0][LANE_W-1:0]  buf_q, buf_next, placed;
    logic [FILL_W-1:0]               fill, fill_next, base;
    logic [CNT_W-1:0]                cnt;
    logic                            pop, push;

    always_comb begin
        out_valid = (state == ACCUM) ? (fill >= FULL) : (fill != '0);
        out_last  = (state == FLUSH) && (fill <= FULL);
        out_data  = buf_q[LANES-1:0];
        if (!out_valid) begin
            out_count = '0;
        end else if (fill >= FULL) begin
            out_count = CNT_MAX;
        end else begin
            out_count = CNT_W'(fill);
        end
        pop = out_valid && out_ready;
        // rst_n gates in_ready so the port reads 0 for the whole reset window
        in_ready = rst_n && (state == ACCUM) && ((fill < FULL) || pop);
        push     = in_valid && in_ready;
        cnt      = (in_count > CNT_MAX) ? CNT_MAX : in_count;
        if (pop) begin
            base = (fill >= FULL) ? (fill - FULL) : '0;
        end else begin
            base = fill;
        end
    end

    lane_place_at #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .CNT_W  (CNT_W),
        .BASE_W (FILL_W)
    ) u_place (
        .beat   (in_data),
        .count  (cnt),
        .base   (base),
        .placed (placed)
    );

    always_comb begin
        buf_next   = pop ? (buf_q >> WORD_BITS) : buf_q;
        fill_next  = base;
        state_next = state;
        // Lanes at or above base are zero after the shift, so OR merges the beat
        if (push) begin
            buf_next  = buf_next | placed;
            fill_next = base + FILL_W'(cnt);
        end
        case (state)
            ACCUM: begin
                if (push && in_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if ((pop && out_last) || (fill == '0)) begin
                    state_next = ACCUM;
                    fill_next  = '0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            fill  <= '0;
            buf_q <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
            buf_q <= buf_next;
        end
    end

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer with a lane-queue reference model.
module tb_lane_packer;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid, in_ready, in_last;
    logic              out_valid, out_ready, out_last;
    logic [15:0][15:0] in_data, out_data;
    logic [4:0]        in_count, out_count;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    logic [15:0] q[$];
    bit          flushing;

    always #5 clk = ~clk;

    lane_packer #(.LANES(16), .LANE_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_last  (out_last)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        flushing = 1'b0;
    endtask

    function automatic logic [15:0][15:0] mk(input int start, input int n, input bit garbage);
        logic [15:0][15:0] w;
        for (int i = 0; i < 16; i++) begin
            if (i < n)        w[i] = 16'(start + i);
            else if (garbage) w[i] = 16'(16'hA5A0 + i);
            else              w[i] = 16'h0;
        end
        return w;
    endfunction

    // Drive one cycle of inputs, compare every output against the model, then advance the model.
    task automatic step(input bit v, input int n, input logic [15:0][15:0] d, input bit last, input bit ordy);
        int                size, ec, take;
        bit                ev, el, er, pop, push;
        logic [15:0][15:0] ed;
        @(negedge clk);
        in_valid  = v;
        in_count  = 5'(n);
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        #1;
        size = q.size();
        ev   = flushing ? (size > 0) : (size >= 16);
        ec   = ev ? ((size < 16) ? size : 16) : 0;
        el   = flushing && (size <= 16);
        for (int i = 0; i < 16; i++) ed[i] = (i < size) ? q[i] : 16'h0;
        pop  = ev && ordy;
        er   = !flushing && ((size < 16) || pop);
        push = v && er;
        check("out_valid", out_valid, ev);
        check("out_count", out_count, ec);
        check("out_last",  out_last,  el);
        check("out_data",  out_data,  ed);
        check("in_ready",  in_ready,  er);
        if (pop) begin
            pops++;
            repeat ((size < 16) ? size : 16) q.delete(0);
            if (flushing && size <= 16) flushing = 1'b0;
        end else if (flushing && size == 0) begin
            flushing = 1'b0;
        end
        if (push) begin
            take = (n > 16) ? 16 : n;
            for (int i = 0; i < take; i++) q.push_back(d[i]);
            if (last) flushing = 1'b1;
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, '0, 1'b0, ordy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0][15:0] w;
        in_valid = 0; in_count = '0; in_data = '0; in_last = 0; out_ready = 0;
        model_reset();

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last",  out_last,  0);
        check("rst_out_count", out_count, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_in_ready",  in_ready,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // four 4-lane beats form one word
        for (int b = 0; b < 4; b++) step(1'b1, 4, mk(1 + 4 * b, 4, 1'b0), 1'b0, 1'b1);
        check("lat_no_valid_yet", out_valid, 0);
        idle(1'b0);
        check("w1_valid", out_valid, 1);
        check("w1_count", out_count, 16);
        check("w1_data",  out_data,  mk(1, 16, 1'b0));
        check("w1_last",  out_last,  0);
        idle(1'b1);

        // 10 + 10 with in_last
        step(1'b1, 10, mk(100, 10, 1'b0), 1'b0, 1'b1);
        step(1'b1, 10, mk(200, 10, 1'b0), 1'b1, 1'b1);
        idle(1'b1);
        check("p2_w1_count", out_count, 16);
        check("p2_w1_last",  out_last,  0);
        idle(1'b1);
        check("p2_w2_count", out_count, 4);
        check("p2_w2_last",  out_last,  1);
        check("p2_w2_data",  out_data,  mk(206, 4, 1'b0));
        idle(1'b1);
        check("p2_back_ready", in_ready, 1);
        check("p2_back_empty", out_valid, 0);

        // full-rate streaming
        pops = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16, mk(1000 + 16 * k, 16, 1'b0), 1'b0, 1'b1);
            check("stream_in_ready", in_ready, 1);
        end
        idle(1'b1);
        check("stream_words", pops, 8);

        // backpressure with fill=20
        step(1'b1, 10, mk('h100, 10, 1'b0), 1'b0, 1'b0);
        step(1'b1, 10, mk('h110, 10, 1'b0), 1'b0, 1'b0);
        w = mk('h100, 10, 1'b0);
        for (int i = 10; i < 16; i++) w[i] = 16'('h110 + i - 10);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16, mk('h200, 16, 1'b0), 1'b0, 1'b0);
            check("bp_in_ready", in_ready, 0);
            check("bp_data", out_data, w);
        end
        step(1'b1, 3, mk('h300, 3, 1'b0), 1'b0, 1'b1);
        idle(1'b0);
        w = mk('h116, 4, 1'b0);
        for (int i = 4; i < 7; i++) w[i] = 16'('h300 + i - 4);
        check("bp_lane4_data", out_data, w);
        check("bp_after_valid", out_valid, 0);
        step(1'b1, 0, '0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // clamp and garbage masking
        step(1'b1, 5, mk('h400, 5, 1'b1), 1'b0, 1'b0);
        step(1'b1, 20, mk('h500, 20, 1'b0), 1'b0, 1'b0);
        idle(1'b0);
        w = mk('h400, 5, 1'b0);
        for (int i = 5; i < 16; i++) w[i] = 16'('h500 + i - 5);
        check("clamp_data", out_data, w);
        check("clamp_count", out_count, 16);
        step(1'b1, 0, '0, 1'b1, 1'b1);
        idle(1'b1);
        check("clamp_tail_count", out_count, 5);
        check("clamp_tail_last", out_last, 1);
        check("clamp_tail_data", out_data, mk('h50B, 5, 1'b0));

        // empty flush
        step(1'b1, 0, '0, 1'b1, 1'b1);
        step(1'b1, 2, mk('h600, 2, 1'b0), 1'b0, 1'b1);
        check("empty_flush_ready", in_ready, 0);
        check("empty_flush_valid", out_valid, 0);
        step(1'b1, 2, mk('h600, 2, 1'b0), 1'b0, 1'b1);
        check("empty_flush_resume", in_ready, 1);
        step(1'b1, 0, '0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // async reset mid-flush
        step(1'b1, 12, mk('h700, 12, 1'b0), 1'b1, 1'b0);
        idle(1'b0);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_last",  out_last,  1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_last",  out_last,  0);
        check("async_rst_count", out_count, 0);
        check("async_rst_ready", in_ready,  0);
        check("async_rst_data",  out_data,  0);
        model_reset();
        #3 rst_n = 1'b1;
        idle(1'b1);
        check("post_rst_ready", in_ready, 1);
        step(1'b1, 16, mk('h800, 16, 1'b0), 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
